// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: pipeline stage register with 2-entry skid buffer, valid/ready on both sides,
// hard/soft stall and flush that is deferred while hard-stalled.
module pipe_stage_skid_reg #(
  parameter int PC_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_FLUSH = 3,
  parameter logic [PC_W-1:0] RST_PC = PC_W'(32'h1c00_0000)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_hard,
  input  logic                 stall_soft,
  input  logic [NUM_FLUSH-1:0] flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [DATA_W-1:0]    out_data,
  output logic [1:0]           occupancy
);
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d, flush_pend_q, flush_pend_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              any_flush, hold, in_fire, out_fire;
  always_comb begin
    any_flush    = (|flush) | flush_pend_q;
    hold         = stall_hard | (stall_soft & ~any_flush);
    in_ready     = rst_n & ~skid_v_q & ~hold & ~any_flush;
    in_fire      = in_valid & in_ready;
    out_fire     = main_v_q & out_ready & ~hold;
    main_v_d     = main_v_q;
    main_pc_d    = main_pc_q;
    main_data_d  = main_data_q;
    skid_v_d     = skid_v_q;
    skid_pc_d    = skid_pc_q;
    skid_data_d  = skid_data_q;
    flush_pend_d = flush_pend_q;
    // a hard stall only records the flush; it takes effect on the first unstalled cycle
    if (stall_hard) begin
      flush_pend_d = any_flush;
    end else if (any_flush) begin
      main_v_d     = 1'b0;
      skid_v_d     = 1'b0;
      flush_pend_d = 1'b0;
    end else if (!hold) begin
      if (!main_v_q || out_fire) begin
        main_v_d    = skid_v_q | in_fire;
        main_pc_d   = skid_v_q ? skid_pc_q : in_pc;
        main_data_d = skid_v_q ? skid_data_q : in_data;
        skid_v_d    = 1'b0;
      end else if (in_fire) begin
        skid_v_d    = 1'b1;
        skid_pc_d   = in_pc;
        skid_data_d = in_data;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q     <= 1'b0;
      main_pc_q    <= RST_PC;
      main_data_q  <= '0;
      skid_v_q     <= 1'b0;
      skid_pc_q    <= RST_PC;
      skid_data_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      main_v_q     <= main_v_d;
      main_pc_q    <= main_pc_d;
      main_data_q  <= main_data_d;
      skid_v_q     <= skid_v_d;
      skid_pc_q    <= skid_pc_d;
      skid_data_q  <= skid_data_d;
      flush_pend_q <= flush_pend_d;
    end
  end
  assign out_valid = main_v_q;
  assign out_pc    = main_v_q ? main_pc_q : RST_PC;
  assign out_data  = main_v_q ? main_data_q : '0;
  assign occupancy = 2'(main_v_q) + 2'(skid_v_q);
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed scenarios plus randomized traffic checked against a FIFO-queue model.
module tb_pipe_stage_skid_reg;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;
  typedef struct packed {logic [31:0] pc; logic [31:0] d;} beat_t;
  logic clk = 0, rst_n = 0, stall_hard = 0, stall_soft = 0, in_valid = 0, out_ready = 0;
  logic [2:0] flush = '0;
  logic [31:0] in_pc = '0, in_data = '0;
  logic in_ready, out_valid;
  logic [31:0] out_pc, out_data;
  logic [1:0] occupancy;
  int checks = 0, errors = 0;
  beat_t mq[$];
  bit pend = 0;
  pipe_stage_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_hard(stall_hard), .stall_soft(stall_soft), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  function automatic bit m_any_flush();
    return (|flush) || pend;
  endfunction
  function automatic bit m_hold();
    return stall_hard || (stall_soft && !m_any_flush());
  endfunction
  function automatic bit m_ready();
    return rst_n && mq.size() < 2 && !m_hold() && !m_any_flush();
  endfunction
  function automatic logic [97:0] m_expect();
    beat_t h;
    h = mq.size() > 0 ? mq[0] : {RST_PC, 32'h0};
    return {m_ready(), mq.size() > 0, h.pc, h.d, 2'(mq.size())};
  endfunction
  task automatic tick();
    bit anyf, inf, outf;
    anyf = m_any_flush();
    inf  = in_valid && m_ready();
    outf = mq.size() > 0 && out_ready && !m_hold();
    @(posedge clk);
    if (stall_hard) pend = pend || (|flush);
    else if (anyf) begin
      mq.delete();
      pend = 0;
    end else if (!stall_soft) begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back({in_pc, in_data});
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_pc, out_data, occupancy} !== {1'b0, 1'b0, RST_PC, 32'h0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b pc=%h d=%h occ=%0d", in_ready, out_valid, out_pc, out_data, occupancy);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask
  task automatic test_pass_through();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_pc = RST_PC + 32'(4 * i);
      in_data = $urandom;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL pass_ready[%0d] got %b want 1", i, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_pc, out_data, occupancy} !== {1'b1, RST_PC + 32'(4 * i), in_data, 2'd1}) begin
        errors++;
        $display("FAIL pass_beat[%0d] got v=%b pc=%h d=%h occ=%0d want pc=%h d=%h", i, out_valid, out_pc, out_data, occupancy, RST_PC + 32'(4 * i), in_data);
      end
    end
    in_valid = 0;
    tick();
    checks++;
    if (occupancy !== 2'd0) begin
      errors++;
      $display("FAIL pass_drain occ got %0d want 0", occupancy);
    end
  endtask
  task automatic test_skid();
    logic [31:0] da, db;
    da = $urandom;
    db = $urandom;
    out_ready = 0;
    in_valid = 1;
    in_pc = 32'h100;
    in_data = da;
    tick();
    in_pc = 32'h104;
    in_data = db;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_accept_b got %b want 1", in_ready);
    end
    tick();
    checks++;
    if ({in_ready, out_pc, out_data, occupancy} !== {1'b0, 32'h100, da, 2'd2}) begin
      errors++;
      $display("FAIL skid_full got rdy=%b pc=%h d=%h occ=%0d want rdy=0 pc=100 occ=2", in_ready, out_pc, out_data, occupancy);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    checks++;
    if ({out_valid, out_pc, out_data, occupancy} !== {1'b1, 32'h104, db, 2'd1}) begin
      errors++;
      $display("FAIL skid_second got v=%b pc=%h d=%h occ=%0d want pc=104", out_valid, out_pc, out_data, occupancy);
    end
    tick();
    checks++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL skid_drain got v=%b occ=%0d want 0 0", out_valid, occupancy);
    end
  endtask
  task automatic test_soft_vs_flush();
    out_ready = 0;
    in_valid = 1;
    in_pc = 32'h200;
    in_data = $urandom;
    tick();
    in_valid = 0;
    stall_soft = 1;
    flush = 3'b010;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL soft_flush_ready got %b want 0", in_ready);
    end
    tick();
    stall_soft = 0;
    flush = '0;
    #1;
    checks++;
    if ({out_valid, out_pc, out_data, occupancy} !== {1'b0, RST_PC, 32'h0, 2'd0}) begin
      errors++;
      $display("FAIL soft_flush got v=%b pc=%h d=%h occ=%0d want bubble", out_valid, out_pc, out_data, occupancy);
    end
  endtask
  task automatic test_deferred_flush();
    logic [31:0] d;
    d = $urandom;
    out_ready = 0;
    in_valid = 1;
    in_pc = 32'h300;
    in_data = d;
    tick();
    in_valid = 0;
    stall_hard = 1;
    for (int c = 1; c <= 4; c++) begin
      flush = (c == 2) ? 3'b001 : 3'b000;
      tick();
      checks++;
      if ({out_valid, out_pc, out_data, occupancy} !== {1'b1, 32'h300, d, 2'd1}) begin
        errors++;
        $display("FAIL defer_frozen[%0d] got v=%b pc=%h d=%h occ=%0d want pc=300 occ=1", c, out_valid, out_pc, out_data, occupancy);
      end
    end
    flush = '0;
    stall_hard = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL defer_release_ready got %b want 0", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_pc, occupancy} !== {1'b0, RST_PC, 2'd0}) begin
      errors++;
      $display("FAIL defer_applied got v=%b pc=%h occ=%0d want 0 %h 0", out_valid, out_pc, occupancy, RST_PC);
    end
  endtask
  task automatic test_hard_freeze();
    logic [31:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    out_ready = 0;
    in_valid = 1;
    in_pc = 32'h400;
    in_data = d0;
    tick();
    in_pc = 32'h404;
    in_data = d1;
    tick();
    stall_hard = 1;
    out_ready = 1;
    in_pc = 32'h408;
    in_data = $urandom;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL freeze_ready got %b want 0", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({in_ready, out_valid, out_pc, out_data, occupancy} !== {1'b0, 1'b1, 32'h400, d0, 2'd2}) begin
        errors++;
        $display("FAIL freeze_hold[%0d] got rdy=%b v=%b pc=%h d=%h occ=%0d", c, in_ready, out_valid, out_pc, out_data, occupancy);
      end
    end
    stall_hard = 0;
    in_valid = 0;
    tick();
    checks++;
    if ({out_pc, out_data, occupancy} !== {32'h404, d1, 2'd1}) begin
      errors++;
      $display("FAIL freeze_resume got pc=%h d=%h occ=%0d want pc=404 occ=1", out_pc, out_data, occupancy);
    end
    tick();
  endtask
  task automatic test_async_reset();
    out_ready = 0;
    in_valid = 1;
    in_pc = 32'h500;
    in_data = $urandom;
    tick();
    in_pc = 32'h504;
    tick();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_pc, out_data, occupancy} !== {1'b0, 1'b0, RST_PC, 32'h0, 2'd0}) begin
      errors++;
      $display("FAIL async_reset got rdy=%b v=%b pc=%h occ=%0d", in_ready, out_valid, out_pc, occupancy);
    end
    mq.delete();
    pend = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_release_ready got %b want 1", in_ready);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      stall_hard = $urandom_range(0, 9) == 0;
      stall_soft = $urandom_range(0, 7) == 0;
      flush = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      in_valid = $urandom_range(0, 3) != 0;
      in_pc = $urandom;
      in_data = $urandom;
      out_ready = $urandom_range(0, 9) < 7;
      #1;
      checks++;
      if ({in_ready, out_valid, out_pc, out_data, occupancy} !== m_expect()) begin
        errors++;
        $display("FAIL random[%0d] got rdy=%b v=%b pc=%h d=%h occ=%0d want %h", i, in_ready, out_valid, out_pc, out_data, occupancy, m_expect());
      end
      tick();
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_skid();
    test_soft_vs_flush();
    test_deferred_flush();
    test_hard_freeze();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
